// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial boot loader: FSM states, frame constants
// and the count-field sizing helper.
package serial_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_CSUM
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         LEN_W_DEF     = 16;
   localparam int         ADDR_W_DEF    = 32;
   localparam int         ADDR_BYTES    = 4;
   localparam int         CSUM_W        = 8;

   // Number of little-endian bytes carrying a count field of len_w bits.
   function automatic int count_bytes(input int len_w);
      return (len_w + 7) / 8;
   endfunction

   localparam int COUNT_BYTES = count_bytes(LEN_W_DEF);

endpackage

// File: rtl/serial_word_pack.sv
// Byte-to-word assembler: places successive bytes into little-endian lanes of
// a 32-bit word. 'word' shows the word as it will be once byte_in is taken,
// 'full' says the next byte completes the word.
module serial_word_pack (
   input  logic        clock,
   input  logic        reset,
   input  logic        clr,
   input  logic [7:0]  byte_in,
   input  logic        byte_vld,
   output logic [31:0] word,
   output logic        full
);

   logic [1:0]  lane;
   logic [31:0] word_q;

   // Merge the incoming byte into its lane of the partially built word.
   always_comb begin
      word                       = word_q;
      word[{lane, 3'b000} +: 8]  = byte_in;
      full                       = (lane == 2'd3);
   end

   // Lane index advances per byte and restarts whenever the owner clears it.
   always_ff @(posedge clock) begin
      if (reset || clr)
         lane <= 2'd0;
      else if (byte_vld)
         lane <= lane + 2'd1;
   end

   // Partial word storage; every lane is rewritten before a word is used.
   always_ff @(posedge clock) begin
      if (byte_vld)
         word_q <= word;
   end

endmodule

// File: rtl/serial_loader.sv
// Framed byte-stream boot loader: SYNC, ADDR(4 LE), COUNT(LE words), DATA,
// optionally CSUM. Emits 32-bit word writes and reports the entry address.
// Define SERIAL_LOADER_CHECKSUM_EN to add the trailing checksum byte check.
module serial_loader
   import serial_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         LEN_W     = LEN_W_DEF,
   parameter int         ADDR_W    = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] entry_addr,
   output logic              done,
   output logic              error,
   output logic              busy
);

   localparam int CB       = count_bytes(LEN_W);
   localparam int CNT_SR_W = 8 * CB;
   localparam int IDX_W    = 3;

   state_t              state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [31:0]         addr_sr, addr_sr_n, addr_shift;
   logic [CNT_SR_W-1:0] cnt_sr, cnt_sr_n, cnt_shift;
   logic [CNT_SR_W+7:0] cnt_cat;
   logic [LEN_W-1:0]    words, words_n;
   logic [ADDR_W-1:0]   cand, cand_n;
   logic [ADDR_W-1:0]   mem_addr_n, entry_n;
   logic [31:0]         mem_wdata_n;
   logic                mem_valid_n, done_n, in_ready_n;
   logic                accept, finish, end_frame;
   logic                pack_clr, pack_vld, pack_full;
   logic [31:0]         pack_word;
`ifdef SERIAL_LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0]   sum_q, sum_n, csum_tot;
   logic                error_n;
`endif

   assign accept     = in_valid & in_ready;
   assign busy       = (state != S_IDLE);
   assign addr_shift = {in_data, addr_sr[31:8]};
   assign cnt_cat    = {in_data, cnt_sr};
   assign cnt_shift  = cnt_cat[CNT_SR_W+7:8];
   assign pack_clr   = (state != S_DATA);

   serial_word_pack u_pack (
      .clock    (clock),
      .reset    (reset),
      .clr      (pack_clr),
      .byte_in  (in_data),
      .byte_vld (pack_vld),
      .word     (pack_word),
      .full     (pack_full)
   );

   // Frame parser: next state, byte indices, write request and completion.
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      addr_sr_n   = addr_sr;
      cnt_sr_n    = cnt_sr;
      words_n     = words;
      cand_n      = cand;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      mem_valid_n = mem_valid;
      entry_n     = entry_addr;
      done_n      = 1'b0;
      finish      = 1'b0;
      end_frame   = 1'b0;
      pack_vld    = 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      sum_n       = sum_q;
      error_n     = 1'b0;
      csum_tot    = sum_q + in_data;
`endif
      case (state)
         S_IDLE: begin
            if (accept && (in_data == SYNC_BYTE)) begin
               state_n = S_ADDR;
               idx_n   = '0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
               sum_n   = '0;
`endif
            end
         end
         S_ADDR: begin
            if (accept) begin
               addr_sr_n = addr_shift;
               if (idx == IDX_W'(ADDR_BYTES - 1)) begin
                  mem_addr_n = ADDR_W'(addr_shift);
                  cand_n     = ADDR_W'(addr_shift);
                  state_n    = S_LEN;
                  idx_n      = '0;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         S_LEN: begin
            if (accept) begin
               cnt_sr_n = cnt_shift;
               if (idx == IDX_W'(CB - 1)) begin
                  words_n = cnt_shift[LEN_W-1:0];
                  idx_n   = '0;
                  if (cnt_shift[LEN_W-1:0] == '0)
                     end_frame = 1'b1;
                  else
                     state_n = S_DATA;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               pack_vld = 1'b1;
               if (pack_full) begin
                  mem_wdata_n = pack_word;
                  mem_valid_n = 1'b1;
                  state_n     = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               mem_valid_n = 1'b0;
               mem_addr_n  = mem_addr + ADDR_W'(4);
               words_n     = words - LEN_W'(1);
               if (words == LEN_W'(1))
                  end_frame = 1'b1;
               else
                  state_n = S_DATA;
            end
         end
         S_CSUM: begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
            if (accept) begin
               state_n = S_IDLE;
               finish  = 1'b1;
               if (csum_tot == '0) begin
                  done_n  = 1'b1;
                  entry_n = cand;
               end else begin
                  error_n = 1'b1;
               end
            end
`else
            state_n = S_IDLE;
`endif
         end
         default: state_n = S_IDLE;
      endcase

      if (end_frame) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
         state_n = S_CSUM;
         idx_n   = '0;
`else
         state_n = S_IDLE;
         finish  = 1'b1;
         done_n  = 1'b1;
         entry_n = cand;
`endif
      end

`ifdef SERIAL_LOADER_CHECKSUM_EN
      if (accept && ((state == S_ADDR) || (state == S_LEN) || (state == S_DATA)))
         sum_n = csum_tot;
`endif

      // Stall the receiver while a write is outstanding and on the finish cycle.
      in_ready_n = (state_n != S_WRITE) && !finish;
   end

   // Control and output registers; reset aborts any frame in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         in_ready   <= 1'b1;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         entry_addr <= '0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         in_ready   <= in_ready_n;
         mem_valid  <= mem_valid_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         entry_addr <= entry_n;
         done       <= done_n;
      end
   end

   // Field assembly registers; always fully reloaded before being consumed.
   always_ff @(posedge clock) begin
      addr_sr <= addr_sr_n;
      cnt_sr  <= cnt_sr_n;
      words   <= words_n;
      cand    <= cand_n;
   end

`ifdef SERIAL_LOADER_CHECKSUM_EN
   // Running checksum, restarted at each SYNC byte.
   always_ff @(posedge clock) begin
      sum_q <= sum_n;
   end

   // Rejection pulse for a checksum mismatch.
   always_ff @(posedge clock) begin
      if (reset)
         error <= 1'b0;
      else
         error <= error_n;
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_loader.sv
// Bench for serial_loader: frames are built from the byte-level frame rules,
// expected writes/entry come from a frame-level model and scoreboard.
module tb_serial_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] entry_addr;
   logic        done;
   logic        error;
   logic        busy;

   always #5 clock = ~clock;

   serial_loader dut (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .entry_addr (entry_addr),
      .done       (done),
      .error      (error),
      .busy       (busy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] exp_entry = 32'h0;
   int          done_cnt = 0, err_cnt = 0, wr_cnt = 0;
   int          stall_cfg = 0, cur_stall = 0, stall_cnt = 0;
   bit          stall_rand = 1'b0, gaps = 1'b0, mv_prev = 1'b0;
   logic [31:0] hold_a, hold_d;

   // Memory-side responder and write scoreboard, sampled on the falling edge.
   always @(negedge clock) begin
      if (reset) begin
         mem_ready = 1'b0;
         mv_prev   = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            chk("entry_at_done", 64'(entry_addr), 64'(exp_entry));
            chk("in_ready_done", 64'(in_ready), 64'd0);
         end
         if (error) err_cnt++;
         if (mem_valid) begin
            if (!mv_prev) begin
               hold_a    = mem_addr;
               hold_d    = mem_wdata;
               stall_cnt = 0;
               cur_stall = stall_rand ? int'($urandom_range(0, 3)) : stall_cfg;
            end else begin
               chk("addr_stable", 64'(mem_addr), 64'(hold_a));
               chk("data_stable", 64'(mem_wdata), 64'(hold_d));
            end
            chk("in_ready_write", 64'(in_ready), 64'd0);
            if (stall_cnt >= cur_stall) begin
               mem_ready = 1'b1;
               wr_cnt++;
               chk("write_expected", 64'(exp_addr_q.size() != 0), 64'd1);
               if (exp_addr_q.size() != 0) begin
                  chk("wr_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                  chk("wr_data", 64'(mem_wdata), 64'(exp_data_q.pop_front()));
               end
            end else begin
               mem_ready = 1'b0;
            end
            stall_cnt++;
         end else begin
            mem_ready = 1'b0;
         end
         mv_prev = mem_valid;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      bit got;
      t = 0;
      got = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      while (!got && t < 300) begin
         got = in_ready;
         @(negedge clock);
         t++;
      end
      in_valid = 1'b0;
      if (!got) chk("byte_accept", 64'(got), 64'd1);
      if (gaps && $urandom_range(0, 3) == 0)
         repeat ($urandom_range(1, 3)) @(negedge clock);
   endtask

   // Build one frame from its fields, record expected effects, send it, check.
   task automatic run_frame(input logic [31:0] base, input int cnt, input bit fixed,
                            input logic [31:0] seed, input bit bad, input int junk);
      logic [7:0]  bytes[$];
      logic [7:0]  s, b, cs;
      logic [15:0] c16;
      logic [31:0] w;
      int d0, e0, w0, t;
      for (int j = 0; j < junk; j++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         bytes.push_back(b);
      end
      bytes.push_back(8'hA5);
      s = 8'h00;
      for (int i = 0; i < 4; i++) begin
         b = base[8*i +: 8];
         bytes.push_back(b);
         s = s + b;
      end
      c16 = 16'(cnt);
      for (int i = 0; i < 2; i++) begin
         b = c16[8*i +: 8];
         bytes.push_back(b);
         s = s + b;
      end
      for (int k = 0; k < cnt; k++) begin
         w = fixed ? seed + 32'(k) : $urandom;
         exp_addr_q.push_back(base + 32'(4 * k));
         exp_data_q.push_back(w);
         for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            bytes.push_back(b);
            s = s + b;
         end
      end
      cs = 8'h00 - s;
      if (bad) cs = cs + 8'h01;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      bytes.push_back(cs);
`endif
      if (!bad) exp_entry = base;
      d0 = done_cnt;
      e0 = err_cnt;
      w0 = wr_cnt;
      foreach (bytes[i]) send_byte(bytes[i]);
      t = 0;
      while (done_cnt == d0 && err_cnt == e0 && t < 2000) begin
         @(negedge clock);
         t++;
      end
      repeat (3) @(negedge clock);
      chk("frame_done", 64'(done_cnt - d0), bad ? 64'd0 : 64'd1);
      chk("frame_error", 64'(err_cnt - e0), bad ? 64'd1 : 64'd0);
      chk("frame_writes", 64'(wr_cnt - w0), 64'(cnt));
      chk("exp_q_empty", 64'(exp_addr_q.size()), 64'd0);
      chk("entry_addr", 64'(entry_addr), 64'(exp_entry));
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rb;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_entry", 64'(entry_addr), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Leading garbage is dropped, single word frame
      send_byte(8'h00);
      send_byte(8'hFF);
      run_frame(32'h0000_1000, 1, 1'b1, 32'h0000_0013, 1'b0, 0);

`ifdef SERIAL_LOADER_CHECKSUM_EN
      // Bad checksum, then a good frame
      run_frame(32'h0000_1000, 1, 1'b1, 32'h0000_0013, 1'b1, 0);
      run_frame(32'h0000_3000, 2, 1'b0, 32'h0, 1'b0, 0);
`endif

      // Stalled writes
      stall_cfg = 5;
      run_frame(32'h0000_1000, 3, 1'b0, 32'h0, 1'b0, 0);
      stall_cfg = 0;

      // Empty frame
      run_frame(32'h0000_2000, 0, 1'b0, 32'h0, 1'b0, 0);

      // Address wrap
      run_frame(32'hFFFF_FFFC, 2, 1'b0, 32'h0, 1'b0, 0);

      // Reset in the middle of a data word
      send_byte(8'hA5);
      chk("busy_in_frame", 64'(busy), 64'd1);
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      in_data  = 8'h33;
      in_valid = 1'b1;
      reset    = 1'b1;
      @(negedge clock);
      reset    = 1'b0;
      in_valid = 1'b0;
      exp_entry = 32'h0;
      chk("abort_mem_valid", 64'(mem_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      @(negedge clock);
      run_frame(32'h0000_4000, 2, 1'b0, 32'h0, 1'b0, 1);

      // Randomized frames with random stalls and input gaps
      stall_rand = 1'b1;
      gaps       = 1'b1;
      repeat (8) begin
         rb = $urandom;
`ifdef SERIAL_LOADER_CHECKSUM_EN
         run_frame(rb, int'($urandom_range(0, 4)), 1'b0, 32'h0,
                   $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
`else
         run_frame(rb, int'($urandom_range(0, 4)), 1'b0, 32'h0, 1'b0,
                   int'($urandom_range(0, 3)));
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
